// File: rtl/sram_col_if.sv
// sram_col_if
// Bundles the request handshake from the memory front-end together with the
// cell-level column controls and the sensed bitline levels.
//
//   master : front-end / array side (drives requests and bitline levels)
//   slave  : the column sequencer (drives ready, cell controls, results)
//
// Signals:
//   req_valid, req_ready, req_we, req_addr[AW], req_wdata   request handshake
//   wl[ROWS], pre, drv_en, drv_bl, drv_blb, sae             cell controls
//   bl_sense, blb_sense                                     resolved bitlines
//   rvalid, rdata, rerr, wdone                              completion status
interface sram_col_if #(
    parameter int ROWS = 8,
    parameter int AW   = 3
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic            req_wdata;
    logic [ROWS-1:0] wl;
    logic            pre;
    logic            drv_en;
    logic            drv_bl;
    logic            drv_blb;
    logic            sae;
    logic            bl_sense;
    logic            blb_sense;
    logic            rvalid;
    logic            rdata;
    logic            rerr;
    logic            wdone;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, bl_sense, blb_sense,
        input  req_ready, wl, pre, drv_en, drv_bl, drv_blb, sae,
               rvalid, rdata, rerr, wdone
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, bl_sense, blb_sense,
        output req_ready, wl, pre, drv_en, drv_bl, drv_blb, sae,
               rvalid, rdata, rerr, wdone
    );
endinterface

// File: rtl/sram_col_seq.sv
// sram_col_seq
// Access sequencer for one SRAM column (a bitline pair shared by ROWS cells).
// Turns single-bit read/write requests into wordline, precharge, write-driver
// and sense-enable controls, and samples the sensed bitlines into a read result.
//
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : sram_col_if.slave -- request handshake, cell controls, results
//
// Optional feature (compile-time macro SRAM_COL_WRVERIFY_EN):
//   when defined, every write is followed by a read-back of the same row and
//   wdone reports rerr=1 if the sensed bit differs from the written bit or the
//   sense faulted. When undefined, rerr is always 0 alongside wdone.
//
// Every output is a flop loaded from the next-state decode, so there is no
// combinational path from any input to any output.
module sram_col_seq #(
    parameter int ROWS    = 8,
    parameter int AW      = 3,
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 2
) (
    input  logic      clk,
    input  logic      rst,
    sram_col_if.slave bus
);

    localparam int MAX_CYC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(PRE_CYC - 1);
    localparam logic [CW-1:0] WL_LAST  = CW'(WL_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ACC,
        DRV,
        WACC,
        REC
    } state_t;

    // One-hot row decode; addresses at or above ROWS decode to all zeros.
    function automatic logic [ROWS-1:0] row_decode(input logic [AW-1:0] a);
        logic [ROWS-1:0] d;
        d = '0;
        for (int i = 0; i < ROWS; i++) begin
            d[i] = (a == AW'(i));
        end
        return d;
    endfunction

    state_t          state_q, state_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;

    // Latched request (data only, no reset needed)
    logic            we_q;
    logic            wdata_q;
    logic [AW-1:0]   addr_q;

    // Registered outputs
    logic            ready_q;
    logic [ROWS-1:0] wl_q;
    logic            pre_q;
    logic            drv_en_q;
    logic            drv_bl_q;
    logic            sae_q;
    logic            rvalid_q;
    logic            wdone_q;
    logic            rdata_q;
    logic            rerr_q;

    // Next-cycle output values
    logic            fire;
    logic            we_eff;
    logic            wdata_eff;
    logic [AW-1:0]   addr_eff;
    logic [ROWS-1:0] wl_nxt;
    logic            pre_nxt;
    logic            drv_en_nxt;
    logic            drv_bl_nxt;
    logic            sae_nxt;
    logic            rvalid_nxt;
    logic            wdone_nxt;
    logic            sample;
    logic            sense_fault;

    assign fire = (state_q == IDLE) && bus.req_valid;

    // On the accept edge the request fields are not yet latched, so the
    // first-phase outputs come straight from the request bus.
    assign we_eff    = fire ? bus.req_we    : we_q;
    assign wdata_eff = fire ? bus.req_wdata : wdata_q;
    assign addr_eff  = fire ? bus.req_addr  : addr_q;

    // The edge that closes the last ACC cycle is the sense sample point.
    assign sample      = (state_q == ACC) && (cnt_q == WL_LAST);
    // An out-of-range row leaves both bitlines precharged, so treat it as a fault.
    assign sense_fault = (bus.bl_sense == bus.blb_sense) || !(|row_decode(addr_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_nxt = '0;
                if (fire) begin
                    state_nxt = bus.req_we ? DRV : PRE;
                end
            end
            PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_nxt = ACC;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            ACC: begin
                if (cnt_q == WL_LAST) begin
                    state_nxt = REC;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            DRV: begin
                state_nxt = WACC;
                cnt_nxt   = '0;
            end
            WACC: begin
                if (cnt_q == WL_LAST) begin
`ifdef SRAM_COL_WRVERIFY_EN
                    state_nxt = PRE;
`else
                    state_nxt = REC;
`endif
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            REC: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        pre_nxt    = (state_nxt == PRE);
        drv_en_nxt = (state_nxt == DRV) || (state_nxt == WACC);
        drv_bl_nxt = drv_en_nxt && wdata_eff;
        wl_nxt     = ((state_nxt == ACC) || (state_nxt == WACC)) ? row_decode(addr_eff) : '0;
        sae_nxt    = (state_nxt == ACC) && (cnt_nxt == WL_LAST);
        rvalid_nxt = (state_nxt == REC) && !we_eff;
        wdone_nxt  = (state_nxt == REC) && we_eff;
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            we_q    <= bus.req_we;
            wdata_q <= bus.req_wdata;
            addr_q  <= bus.req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q  <= 1'b1;
            wl_q     <= '0;
            pre_q    <= 1'b0;
            drv_en_q <= 1'b0;
            drv_bl_q <= 1'b0;
            sae_q    <= 1'b0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            rdata_q  <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            ready_q  <= (state_nxt == IDLE);
            wl_q     <= wl_nxt;
            pre_q    <= pre_nxt;
            drv_en_q <= drv_en_nxt;
            drv_bl_q <= drv_bl_nxt;
            sae_q    <= sae_nxt;
            rvalid_q <= rvalid_nxt;
            wdone_q  <= wdone_nxt;
`ifdef SRAM_COL_WRVERIFY_EN
            // Write read-back only updates rerr; rdata keeps the last read.
            if (sample) begin
                if (we_q) begin
                    rerr_q <= sense_fault || (bus.bl_sense != wdata_q);
                end else begin
                    rdata_q <= sense_fault ? 1'b0 : bus.bl_sense;
                    rerr_q  <= sense_fault;
                end
            end
`else
            if (sample) begin
                rdata_q <= sense_fault ? 1'b0 : bus.bl_sense;
                rerr_q  <= sense_fault;
            end else if (wdone_nxt) begin
                // A plain write never reports an error, even after a faulted read.
                rerr_q <= 1'b0;
            end
`endif
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.wl        = wl_q;
    assign bus.pre       = pre_q;
    assign bus.drv_en    = drv_en_q;
    assign bus.drv_bl    = drv_bl_q;
    assign bus.drv_blb   = ~drv_bl_q;
    assign bus.sae       = sae_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.wdone     = wdone_q;
    assign bus.rdata     = rdata_q;
    assign bus.rerr      = rerr_q;

endmodule

// File: tb/tb_sram_col_seq.sv
// tb_sram_col_seq
// Table-driven bench for sram_col_seq (ROWS=8, AW=4, PRE_CYC=WL_CYC=2).
// Each vector is one request; the per-cycle control pattern is predicted from
// the access timing, and the completion strobe is checked against a scoreboard
// entry pushed when the request is driven. Honours SRAM_COL_WRVERIFY_EN.
module tb_sram_col_seq;

    localparam int ROWS    = 8;
    localparam int AW      = 4;
    localparam int PRE_CYC = 2;
    localparam int WL_CYC  = 2;
    localparam int OW      = ROWS + 8;
`ifdef SRAM_COL_WRVERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic          wdata;
        logic          bl;
        logic          blb;
        logic          exp_rdata;
        logic          exp_rerr;
    } vec_t;

    typedef struct {
        logic we;
        logic rdata;
        logic rerr;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[11];

    localparam logic [OW-1:0] RESET_OBS = {{ROWS{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    sram_col_if #(.ROWS(ROWS), .AW(AW)) bus ();

    sram_col_seq #(
        .ROWS(ROWS), .AW(AW), .PRE_CYC(PRE_CYC), .WL_CYC(WL_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic we, input logic [AW-1:0] addr, input logic wdata,
                                input logic bl, input logic blb, input logic rd, input logic re);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.bl = bl; v.blb = blb;
        v.exp_rdata = rd; v.exp_rerr = re;
        return v;
    endfunction

    function automatic int txn_lat(input logic we);
        if (we) return WL_CYC + 2 + (VERIFY ? PRE_CYC + WL_CYC : 0);
        return PRE_CYC + WL_CYC + 1;
    endfunction

    function automatic logic [OW-1:0] obs();
        return {bus.wl, bus.pre, bus.drv_en, bus.drv_bl, bus.drv_blb, bus.sae,
                bus.rvalid, bus.wdone, bus.req_ready};
    endfunction

    // Expected controls k cycles after the accept cycle.
    function automatic logic [OW-1:0] exp_obs(input logic we, input logic [AW-1:0] addr,
                                              input logic wdata, input int k);
        logic pre, wlon, drv, sae, dbl;
        logic [ROWS-1:0] w;
        int rs, last;
        pre = 0; wlon = 0; drv = 0; sae = 0; rs = 0;
        last = txn_lat(we);
        if (!we) begin
            rs = 1;
        end else begin
            drv  = (k >= 1) && (k <= WL_CYC + 1);
            wlon = (k >= 2) && (k <= WL_CYC + 1);
            if (VERIFY) rs = WL_CYC + 2;
        end
        if (rs > 0) begin
            pre = (k >= rs) && (k < rs + PRE_CYC);
            if ((k >= rs + PRE_CYC) && (k < rs + PRE_CYC + WL_CYC)) wlon = 1;
            sae = (k == rs + PRE_CYC + WL_CYC - 1);
        end
        w = '0;
        if (wlon && (int'(addr) < ROWS)) w = ROWS'(1) << addr;
        dbl = drv & wdata;
        return {w, pre, drv, dbl, ~dbl, sae, (!we && k == last), (we && k == last), (k > last)};
    endfunction

    // Advance to the next falling edge and score any completion strobe there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus.rvalid || bus.wdone) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d got rvalid=%0b wdone=%0b required none",
                         cyc, bus.rvalid, bus.wdone);
            end else begin
                e = sb.pop_front();
                if (bus.rvalid != !e.we || bus.wdone != e.we || cyc != e.due ||
                    bus.rerr != e.rerr || (!e.we && bus.rdata != e.rdata)) begin
                    errors++;
                    $display("FAIL strobe cyc=%0d got rv=%0b wd=%0b rdata=%0b rerr=%0b required cyc=%0d we=%0b rdata=%0b rerr=%0b",
                             cyc, bus.rvalid, bus.wdone, bus.rdata, bus.rerr, e.due, e.we, e.rdata, e.rerr);
                end
            end
        end
    endtask

    task automatic check_obs(input string name, input int k, input logic [OW-1:0] exp);
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%b required=%b", name, k, obs(), exp);
        end
    endtask

    task automatic check_result_regs(input string name);
        checks++;
        if ({bus.rdata, bus.rerr} !== 2'b00) begin
            errors++;
            $display("FAIL %s rdata_rerr got=%b required=00", name, {bus.rdata, bus.rerr});
        end
    endtask

    task automatic run_txn(input string name, input vec_t v);
        int   t;
        int   last;
        exp_t e;
        t = 0;
        while (!bus.req_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s ready_timeout got=0 required=1", name);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.bl_sense  = v.bl;
        bus.blb_sense = v.blb;
        last    = txn_lat(v.we);
        e.we    = v.we;
        e.rdata = v.exp_rdata;
        e.rerr  = v.exp_rerr;
        e.due   = cyc + last;
        sb.push_back(e);
        tick();
        // Scramble the request bus after accept; the sequencer must have latched it.
        bus.req_valid = 1'b0;
        bus.req_we    = ~v.we;
        bus.req_addr  = ~v.addr;
        bus.req_wdata = ~v.wdata;
        for (int k = 1; k <= last + 1; k++) begin
            check_obs(name, k, exp_obs(v.we, v.addr, v.wdata, k));
            if (k <= last) tick();
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = 1'b0;
        bus.bl_sense  = 1'b0;
        bus.blb_sense = 1'b1;

        vecs[0]  = mk(1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 4'd5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[3]  = mk(1'b0, 4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[4]  = mk(1'b0, 4'd7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[6]  = mk(1'b1, 4'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b1, 4'd2,  1'b1, 1'b0, 1'b1, 1'b0, VERIFY);
        vecs[8]  = mk(1'b1, 4'd6,  1'b1, 1'b1, 1'b1, 1'b0, VERIFY);
        vecs[9]  = mk(1'b0, 4'd1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[10] = mk(1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, VERIFY);

        // Reset, then idle: everything at reset values.
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_obs("idle_after_reset", i, RESET_OBS);
            check_result_regs("idle_after_reset");
        end

        for (int i = 0; i < 11; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the middle of a read drops it with no strobe.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'd4;
        bus.bl_sense  = 1'b1;
        bus.blb_sense = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        check_obs("abort_mid_read", 3, exp_obs(1'b0, 4'd4, 1'b0, 3));
        rst = 1'b1;
        tick();
        check_obs("abort_reset_vals", 4, RESET_OBS);
        check_result_regs("abort_reset_vals");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_obs("abort_no_strobe", 5 + i, RESET_OBS);
        end
        run_txn("post_reset_read", mk(1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
